// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Byte-stream valid/ready handshake between a boot byte source
//               and the program loader.
//                 byte_valid : source has a byte on byte_data
//                 byte_data  : stream byte
//                 byte_ready : loader accepts a byte this cycle
//               Modport master = byte source, slave = loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );
endinterface : prog_loader_if
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Boot-time program loader. Receives a 2-byte little-endian word
//               count followed by the payload over a byte stream, assembles
//               little-endian 32-bit words and writes them sequentially into
//               the instruction memory from byte address 0. Holds the core in
//               reset until the load completes successfully.
// Ports       : clk, rst (async active-low), start (one-cycle load pulse),
//               bus (byte stream, slave side), mem_we/mem_addr/mem_wdata
//               (instruction memory write port), core_hold, busy, done, error,
//               words_loaded.
// Option      : LOADER_CHECKSUM_EN - expect a trailing XOR checksum byte over
//               the payload; mismatch ends in ERROR.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 256,
    parameter int COUNT_WIDTH   = 16
) (
    input  wire                      clk,
    input  wire                      rst,
    input  wire                      start,
    prog_loader_if.slave             bus,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     core_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [COUNT_WIDTH-1:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    // Header count is 16 bits; one extra bit keeps the compare unsigned-safe.
    localparam logic [16:0] c_mem_size = 17'(MEM_SIZE);

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [1:0]               byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0]    word_q, word_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [COUNT_WIDTH-1:0]   words_loaded_q, words_loaded_d;
    logic                     byte_ready_q, byte_ready_d;
    logic                     core_hold_q, core_hold_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
`endif

    logic                     xfer;
    logic [15:0]              hdr_count;
    logic [COUNT_WIDTH-1:0]   wl_next;
    logic [DATA_WIDTH-1:0]    word_next;

    assign xfer      = bus.byte_valid && byte_ready_q;
    assign hdr_count = {bus.byte_data, count_q[7:0]};
    assign wl_next   = words_loaded_q + COUNT_WIDTH'(1);
    // Shift in from the top: after four bytes the first byte sits in bits 7:0.
    assign word_next = {bus.byte_data, word_q[DATA_WIDTH-1:8]};

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        byte_idx_d     = byte_idx_q;
        word_d         = word_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        words_loaded_d = words_loaded_q;
        done_d         = done_q;
        error_d        = error_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d         = csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d        = S_HDR0;
                    done_d         = 1'b0;
                    error_d        = 1'b0;
                    words_loaded_d = '0;
                    byte_idx_d     = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d         = 8'h00;
`endif
                end
            end
            S_HDR0: begin
                if (xfer) begin
                    count_d = COUNT_WIDTH'(bus.byte_data);
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    count_d = COUNT_WIDTH'(hdr_count);
                    if ({1'b0, hdr_count} > c_mem_size) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else if (hdr_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d     = word_next;
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.byte_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d       = 1'b1;
                        mem_wdata_d    = word_next;
                        mem_addr_d     = ADDRESS_WIDTH'({words_loaded_q, 2'b00});
                        words_loaded_d = wl_next;
                        if (wl_next == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    if (bus.byte_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so they are
        // registered yet line up with the state they describe.
        busy_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
              || (state_d == S_CSUM)
`endif
              ;
        byte_ready_d = busy_d;
        core_hold_d  = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            byte_idx_q     <= 2'd0;
            word_q         <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            words_loaded_q <= '0;
            byte_ready_q   <= 1'b0;
            core_hold_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q         <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            byte_idx_q     <= byte_idx_d;
            word_q         <= word_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            words_loaded_q <= words_loaded_d;
            byte_ready_q   <= byte_ready_d;
            core_hold_q    <= core_hold_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign words_loaded   = words_loaded_q;
    assign core_hold      = core_hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Directed and randomized
//               loads are compared against a word-level reference model built
//               from the payload byte list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
    localparam int MEM_SIZE = 256;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [15:0] cap_wl[$];

    prog_loader_if bus ();

    prog_loader #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(32),
        .MEM_SIZE     (MEM_SIZE),
        .COUNT_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .start       (start),
        .bus         (bus),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .core_hold   (core_hold),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_wdata);
            cap_wl.push_back(words_loaded);
        end
    end

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({mem_we, bus.byte_ready, core_hold, busy, done, error} !== 6'b001000 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || words_loaded !== 16'h0)
            $display("FAIL %s: we/rdy/hold/busy/done/err=%b addr=%h data=%h wl=%0d, required 001000 0 0 0",
                     tag, {mem_we, bus.byte_ready, core_hold, busy, done, error},
                     mem_addr, mem_wdata, words_loaded);
        else n_pass++;
    endtask

    // Called and returns on a negedge. Transfers exactly one byte.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget = 100;
        int g = 0;
        while (gaps && $urandom_range(0, 2) == 0 && g < 8) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
            @(negedge clk);
            g++;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            $display("FAIL byte_timeout: byte_ready=%b after 100 cycles, required 1", bus.byte_ready);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic do_start(input string tag);
        cap_addr.delete();
        cap_data.delete();
        cap_wl.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({bus.byte_ready, core_hold, busy, done, error} !== 5'b11100 || words_loaded !== 16'd0)
            $display("FAIL %s_start: rdy/hold/busy/done/err=%b wl=%0d, required 11100 wl=0",
                     tag, {bus.byte_ready, core_hold, busy, done, error}, words_loaded);
        else n_pass++;
    endtask

    // Full load: header, payload, optional checksum, then model comparison.
    task automatic run_load(input int count, input logic [7:0] pl[$], input bit gaps,
                            input bit bad_csum, input bit mid_start, input string tag);
        logic [7:0]  x = 8'h00;
        bit          valid_cnt;
        bit          exp_ok;
        int          nwords;
        logic [31:0] exp_w;
        valid_cnt = (count <= MEM_SIZE);
        nwords    = valid_cnt ? count : 0;
        foreach (pl[i]) x ^= pl[i];
`ifdef LOADER_CHECKSUM_EN
        exp_ok = valid_cnt && !bad_csum;
`else
        exp_ok = valid_cnt;
`endif
        do_start(tag);
        send_byte(8'(count), gaps);
        send_byte(8'(count >> 8), gaps);
        for (int i = 0; i < pl.size(); i++) begin
            send_byte(pl[i], gaps);
            if (mid_start && i == 5) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (valid_cnt) send_byte(bad_csum ? (x ^ 8'h01) : x, gaps);
`else
        if (nwords > 0) begin
            n_checks++;
            if ({mem_we, done, core_hold} !== 3'b110)
                $display("FAIL %s_last_cycle: we/done/hold=%b, required 110", tag, {mem_we, done, core_hold});
            else n_pass++;
        end
`endif
        n_checks++;
        if ({busy, bus.byte_ready} !== 2'b00)
            $display("FAIL %s_busy_fall: busy/rdy=%b, required 00", tag, {busy, bus.byte_ready});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_we !== 1'b0)
            $display("FAIL %s_we_pulse: mem_we=%b, required 0", tag, mem_we);
        else n_pass++;
        n_checks++;
        if ({done, error, core_hold} !== {exp_ok, !exp_ok, !exp_ok} || words_loaded !== 16'(nwords))
            $display("FAIL %s_status: done/err/hold=%b wl=%0d, required %b wl=%0d", tag,
                     {done, error, core_hold}, words_loaded, {exp_ok, !exp_ok, !exp_ok}, nwords);
        else n_pass++;
        n_checks++;
        if (cap_addr.size() != nwords)
            $display("FAIL %s_nwrites: %0d writes, required %0d", tag, cap_addr.size(), nwords);
        else begin
            n_pass++;
            for (int k = 0; k < nwords; k++) begin
                exp_w = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
                n_checks++;
                if (cap_addr[k] !== 32'(k * 4) || cap_data[k] !== exp_w || cap_wl[k] !== 16'(k + 1))
                    $display("FAIL %s_write%0d: addr=%h data=%h wl=%0d, required addr=%h data=%h wl=%0d",
                             tag, k, cap_addr[k], cap_data[k], cap_wl[k], k * 4, exp_w, k + 1);
                else n_pass++;
            end
            if (nwords > 0) begin
                n_checks++;
                if (mem_addr !== 32'((nwords - 1) * 4) || mem_wdata !== cap_data[nwords-1])
                    $display("FAIL %s_hold_bus: addr=%h data=%h, required addr=%h data=%h", tag,
                             mem_addr, mem_wdata, (nwords - 1) * 4, cap_data[nwords-1]);
                else n_pass++;
            end
        end
    endtask

    function automatic void rand_payload(input int nwords, output logic [7:0] pl[$]);
        pl.delete();
        for (int i = 0; i < nwords * 4; i++) pl.push_back(8'($urandom));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_two_words();
        logic [7:0] pl[$] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        run_load(2, pl, 1'b0, 1'b0, 1'b0, "two_words");
        n_checks++;
        if (cap_data.size() != 2 || cap_data[0] !== 32'h00000513 || cap_data[1] !== 32'h00100593)
            $display("FAIL two_words_vector: n=%0d d0=%h d1=%h, required 2 00000513 00100593",
                     cap_data.size(), cap_data.size() > 0 ? cap_data[0] : 32'hx,
                     cap_data.size() > 1 ? cap_data[1] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_oversize();
        logic [7:0] pl[$];
        pl.delete();
        run_load(257, pl, 1'b0, 1'b0, 1'b0, "oversize");
        run_load(32'($urandom_range(MEM_SIZE + 1, 65535)), pl, 1'b1, 1'b0, 1'b0, "oversize_rand");
    endtask

    task automatic test_random_valid();
        logic [7:0] pl[$] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(1, pl, 1'b1, 1'b0, 1'b0, "deadbeef");
        n_checks++;
        if (cap_data.size() != 1 || cap_data[0] !== 32'hDEADBEEF)
            $display("FAIL deadbeef_vector: n=%0d, required one write of deadbeef", cap_data.size());
        else n_pass++;
    endtask

    task automatic test_random_loads();
        logic [7:0] pl[$];
        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(1, 9);
            rand_payload(n, pl);
            run_load(n, pl, 1'($urandom), 1'b0, 1'b0, $sformatf("rand%0d", t));
        end
    endtask

    task automatic test_full_memory();
        logic [7:0] pl[$];
        rand_payload(MEM_SIZE, pl);
        run_load(MEM_SIZE, pl, 1'b0, 1'b0, 1'b0, "full_mem");
    endtask

    task automatic test_back_to_back_start_mid_data();
        logic [7:0] pl[$];
        rand_payload(3, pl);
        run_load(3, pl, 1'b0, 1'b0, 1'b1, "mid_start");
    endtask

    task automatic test_start_in_done();
        logic [7:0] pl[$];
        rand_payload(1, pl);
        run_load(1, pl, 1'b0, 1'b0, 1'b0, "pre_done");
        pl.delete();
        // do_start inside checks core_hold is back to 1 the cycle after start.
        run_load(0, pl, 1'b0, 1'b0, 1'b0, "zero_count");
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] pl[$];
        do_start("rst_mid");
        send_byte(8'd4, 1'b0);
        send_byte(8'd0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset_mid_data");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_payload(2, pl);
        run_load(2, pl, 1'b0, 1'b0, 1'b0, "reload_after_reset");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] pl[$] = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_load(1, pl, 1'b0, 1'b0, 1'b0, "csum_good");
        run_load(1, pl, 1'b0, 1'b1, 1'b0, "csum_bad");
        rand_payload(4, pl);
        run_load(4, pl, 1'b1, 1'b1, 1'b0, "csum_bad_rand");
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_two_words();
        test_oversize();
        test_random_valid();
        test_random_loads();
        test_back_to_back_start_mid_data();
        test_start_in_done();
        test_full_memory();
        test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule : tb_prog_loader
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the instruction memory and the processor core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them sequentially into the instruction memory write port starting at byte address 0. While loading, it holds the core in reset; it releases the core once the declared number of words is stored (and, optionally, the checksum passes).

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)
- ADDRESS_WIDTH, 32, instruction memory byte-address width (matches the PC width)
- MEM_SIZE, 256, instruction memory capacity in words
- COUNT_WIDTH, 16, width of the word-count header

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins a load
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable, one-cycle pulse
- mem_addr  out  ADDRESS_WIDTH  byte address of the write (word_index*4)
- mem_wdata  out  DATA_WIDTH  assembled instruction word
- core_hold  out  1  high = keep the processor core in reset
- busy  out  1  load in progress
- done  out  1  load completed successfully (sticky until next start)
- error  out  1  load failed (sticky until next start)
- words_loaded  out  COUNT_WIDTH  number of words written in the current load

## Operation
- Byte handshake: a byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is high in HDR0, HDR1, DATA and CSUM, and low in all other states.
- States:
  - IDLE: waits for start.
  - HDR0: low byte of the word count.
  - HDR1: high byte of the word count.
  - DATA: payload bytes.
  - CSUM: checksum byte (present only with the macro).
  - DONE
  - ERROR
- Transitions:
  - IDLE, DONE or ERROR --start--> HDR0. On this transition, clear done, error and words_loaded; core_hold becomes 1.
  - HDR0 --byte--> HDR1.
  - HDR1 --byte--> DATA if the count is nonzero and count <= MEM_SIZE.
  - HDR1 --byte--> ERROR if count > MEM_SIZE.
  - HDR1 --byte--> CSUM or DONE if count == 0.
  - DATA: bytes fill the word little-endian (first byte = bits 7:0). On the 4th byte, the word is latched to mem_wdata, mem_addr = words_loaded*4, and mem_we pulses. After the last word, go to CSUM (macro on) or DONE.
  - start while busy is ignored.
- Outputs by state:
  - core_hold = 0 only in DONE.
  - busy = 1 in HDR0, HDR1, DATA and CSUM.
  - In ERROR, core_hold stays 1.
- Arithmetic: word index counter is COUNT_WIDTH bits; mem_addr is the index shifted left by 2, zero-extended to ADDRESS_WIDTH. Overflow cannot occur because count <= MEM_SIZE is checked in HDR1.
- Reset (asynchronous, any state, including mid-load):
  - State returns to IDLE.
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, byte_ready=0, core_hold=1, busy=0, done=0, error=0, words_loaded=0.
  - Partially written memory contents are not cleared.

## Timing
- All outputs are registered.
- mem_we rises the cycle after the 4th byte of a word is accepted and lasts exactly one cycle. mem_addr and mem_wdata are stable during that cycle and hold until the next write.
- words_loaded increments in the same cycle mem_we is high.
- Back-to-back bytes are accepted every cycle, so peak throughput is 1 word per 4 cycles. The write of word k overlaps the reception of word k+1.
- Last word (macro off): DONE is entered, done=1 and core_hold=0 in the same cycle as the final mem_we.
- busy falls and byte_ready goes low the cycle after the final byte handshake.
- start in IDLE, DONE or ERROR: byte_ready=1 and core_hold=1 the following cycle.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last payload word, the loader expects one extra byte in CSUM.
  - The expected value is the XOR of all payload bytes (header bytes excluded). With count==0, the expected value is 0x00.
  - Match → DONE; mismatch → ERROR, and the core stays held.
- LOADER_CHECKSUM_EN undefined: the CSUM state and checksum register are absent, and the loader goes straight to DONE after the last word.

## Test plan
- Reset during DATA (after 6 bytes): all outputs return to reset values immediately; the next start reloads from address 0.
- start, header 0x02 0x00, bytes 13 05 00 00 93 05 10 00 (macro off) -> mem_we at addr 0x0 data 0x00000513, then addr 0x4 data 0x00100593; done=1, core_hold=0, words_loaded=2.
- Header count 0x0101 (257 > MEM_SIZE) -> ERROR after HDR1, no mem_we, error=1, core_hold=1; a new start clears error.
- byte_valid toggled randomly with one word 0xDEADBEEF (EF BE AD DE) -> exactly one write with data 0xDEADBEEF; no byte lost or duplicated.
- Macro on, one word 0x00000013 with checksum byte 0x13 -> done=1. Same load with checksum 0x12 -> error=1, core_hold=1.
- start pulsed in the middle of DATA -> ignored, load completes normally; start in DONE -> core_hold returns to 1 the next cycle.
